// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the TFF bank sequencing controller.
package tff_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/tff_carry_sync.sv
// Brings one asynchronous TFF carry into the clk domain: two-flop synchronizer
// plus a registered previous value so a rising edge can be flagged for one cycle.
module tff_carry_sync
  import tff_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_carry,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and edge-history register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_carry;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/tff_bank_ctrl.sv
// Round-robin command sequencer for a bank of temporal flip-flops: clears and
// writes a TFF for a programmed duration, or reads it back by timing its carry.
module tff_bank_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter  int NUM_TFF = 4,
  parameter  int NREQ    = 2,
  parameter  int DUR_W   = 8,
  parameter  int CLR_CYC = 2,
  localparam int IDX_W   = $clog2(NUM_TFF),
  localparam int RID_W   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_op,
  input  logic [NREQ*IDX_W-1:0]    req_idx,
  input  logic [NREQ*DUR_W-1:0]    req_dur,
  output logic                     rsp_valid,
  output logic [RID_W-1:0]         rsp_id,
  output logic [DUR_W-1:0]         rsp_count,
  output logic                     rsp_timeout,
  output logic                     rsp_ovf,
  output logic                     busy,
  output logic [NUM_TFF-1:0]       tff_we,
  output logic [NUM_TFF-1:0]       tff_re,
  output logic [NUM_TFF-1:0]       tff_rstb,
  input  logic [NUM_TFF-1:0]       tff_carry
);

  localparam int CLR_W = $clog2(CLR_CYC + 1);
  localparam logic [DUR_W-1:0]   MAX_READ = {DUR_W{1'b1}};
  localparam logic [NUM_TFF-1:0] TFF_ONE  = {{(NUM_TFF-1){1'b0}}, 1'b1};

  state_e               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [DUR_W-1:0]     r_dur;
  logic [RID_W-1:0]     r_id;
  logic [RID_W-1:0]     r_ptr;
  logic [DUR_W-1:0]     r_cnt;
  logic [CLR_W-1:0]     r_clr_cnt;
  logic                 r_rsp_valid;
  logic [RID_W-1:0]     r_rsp_id;
  logic [DUR_W-1:0]     r_rsp_count;
  logic                 r_rsp_timeout;
  logic                 r_rsp_ovf;
  logic                 r_busy;
  logic [NUM_TFF-1:0]   r_tff_we;
  logic [NUM_TFF-1:0]   r_tff_re;
  logic [NUM_TFF-1:0]   r_tff_rstb;

  state_e               w_state_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DUR_W-1:0]     w_dur_nxt;
  logic [RID_W-1:0]     w_id_nxt;
  logic [RID_W-1:0]     w_ptr_nxt;
  logic [DUR_W-1:0]     w_cnt_nxt;
  logic [CLR_W-1:0]     w_clr_cnt_nxt;
  logic                 w_rsp_valid_nxt;
  logic [RID_W-1:0]     w_rsp_id_nxt;
  logic [DUR_W-1:0]     w_rsp_count_nxt;
  logic                 w_rsp_timeout_nxt;
  logic                 w_rsp_ovf_nxt;
  logic [NUM_TFF-1:0]   w_onehot_nxt;
  logic [NUM_TFF-1:0]   w_we_nxt;
  logic [NUM_TFF-1:0]   w_re_nxt;
  logic [NUM_TFF-1:0]   w_rstb_nxt;

  logic                 w_found;
  logic                 w_accept;
  logic [RID_W-1:0]     w_grant_id;
  logic [NREQ-1:0]      w_grant_vec;
  logic                 w_sel_op;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [DUR_W-1:0]     w_sel_dur;

  logic [NUM_TFF-1:0]   w_sync_level;
  logic [NUM_TFF-1:0]   w_sync_rise;
  logic                 w_level_sel;
  logic                 w_rise_sel;

  for (genvar g = 0; g < NUM_TFF; g++) begin : g_sync
    tff_carry_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_carry (tff_carry[g]),
      .o_level (w_sync_level[g]),
      .o_rise  (w_sync_rise[g])
    );
  end

  assign w_level_sel = w_sync_level[r_idx];
  assign w_rise_sel  = w_sync_rise[r_idx];

  // Round-robin pick: first pass from the pointer upward, second pass wraps to 0
  always_comb begin
    w_found     = 1'b0;
    w_grant_id  = '0;
    w_grant_vec = '0;
    w_sel_op    = OP_WRITE;
    w_sel_idx   = '0;
    w_sel_dur   = '0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && req_valid[j] && ((p == 1) || (j >= int'(r_ptr)))) begin
          w_found        = 1'b1;
          w_grant_id     = RID_W'(j);
          w_grant_vec[j] = 1'b1;
          w_sel_op       = req_op[j];
          w_sel_idx      = req_idx[j*IDX_W +: IDX_W];
          w_sel_dur      = req_dur[j*DUR_W +: DUR_W];
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  assign w_accept  = w_found && (r_state == ST_IDLE) && !rst;
  assign req_ready = w_accept ? w_grant_vec : '0;

  // Next-state logic and next values of every registered output
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_dur_nxt         = r_dur;
    w_id_nxt          = r_id;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_clr_cnt_nxt     = r_clr_cnt;
    w_rsp_id_nxt      = r_rsp_id;
    w_rsp_count_nxt   = r_rsp_count;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_rsp_ovf_nxt     = r_rsp_ovf;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_idx_nxt = w_sel_idx;
          w_dur_nxt = w_sel_dur;
          w_id_nxt  = w_grant_id;
          w_ptr_nxt = (w_grant_id == RID_W'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
          w_clr_cnt_nxt = '0;
          if (w_sel_op == OP_READ) begin
            // Counter holds cycles elapsed since accept, so it starts at 1
            w_cnt_nxt   = DUR_W'(1);
            w_state_nxt = ST_READ;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_CLR;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (r_clr_cnt == CLR_W'(CLR_CYC - 1)) begin
          if (r_dur == '0) begin
            w_state_nxt       = ST_RESP;
            w_rsp_count_nxt   = '0;
            w_rsp_timeout_nxt = 1'b0;
            w_rsp_ovf_nxt     = 1'b0;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      ST_WRITE: begin
        if (r_cnt == r_dur - 1'b1) begin
          w_state_nxt       = ST_RESP;
          w_rsp_count_nxt   = r_dur;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_ovf_nxt     = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_READ: begin
        if (w_rise_sel) begin
          w_state_nxt       = ST_RESP;
          w_rsp_count_nxt   = r_cnt;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_ovf_nxt     = 1'b0;
        end else if (r_cnt == MAX_READ) begin
          w_state_nxt       = ST_RESP;
          w_rsp_count_nxt   = MAX_READ;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_ovf_nxt     = 1'b0;
        end else if ((r_cnt == DUR_W'(1)) && w_level_sel) begin
          w_state_nxt       = ST_RESP;
          w_rsp_count_nxt   = '0;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_ovf_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
    if (w_state_nxt == ST_RESP) begin
      w_rsp_id_nxt = r_id;
    end else begin
      w_rsp_id_nxt = w_rsp_id_nxt;
    end

    w_onehot_nxt = TFF_ONE << w_idx_nxt;
    if (w_state_nxt == ST_WRITE) begin
      w_we_nxt = w_onehot_nxt;
    end else begin
      w_we_nxt = '0;
    end
    if (w_state_nxt == ST_READ) begin
      w_re_nxt = w_onehot_nxt;
    end else begin
      w_re_nxt = '0;
    end
    if (w_state_nxt == ST_CLR) begin
      w_rstb_nxt = ~w_onehot_nxt;
    end else begin
      w_rstb_nxt = '1;
    end
  end

  // State, latched command and registered outputs; reset holds the bank cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_dur         <= '0;
      r_id          <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_clr_cnt     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_count   <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_ovf     <= 1'b0;
      r_busy        <= 1'b0;
      r_tff_we      <= '0;
      r_tff_re      <= '0;
      r_tff_rstb    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_dur         <= w_dur_nxt;
      r_id          <= w_id_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_clr_cnt     <= w_clr_cnt_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_id      <= w_rsp_id_nxt;
      r_rsp_count   <= w_rsp_count_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_rsp_ovf     <= w_rsp_ovf_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_tff_we      <= w_we_nxt;
      r_tff_re      <= w_re_nxt;
      r_tff_rstb    <= w_rstb_nxt;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_count   = r_rsp_count;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_ovf     = r_rsp_ovf;
  assign busy        = r_busy;
  assign tff_we      = r_tff_we;
  assign tff_re      = r_tff_re;
  assign tff_rstb    = r_tff_rstb;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Directed bench for tff_bank_ctrl with a behavioral TFF bank: WE counts up on a
// 128-step ring (wrap sets carry), RE counts down and sets carry on reaching zero.
module tb_tff_bank_ctrl;
  import tff_ctrl_pkg::*;

  localparam int NUM_TFF = 4;
  localparam int NREQ    = 2;
  localparam int DUR_W   = 8;
  localparam int CLR_CYC = 2;
  localparam int IDX_W   = 2;
  localparam int RID_W   = 1;
  localparam int RING    = 128;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op = '0;
  logic [NREQ*IDX_W-1:0] req_idx = '0;
  logic [NREQ*DUR_W-1:0] req_dur = '0;
  logic                  rsp_valid;
  logic [RID_W-1:0]      rsp_id;
  logic [DUR_W-1:0]      rsp_count;
  logic                  rsp_timeout;
  logic                  rsp_ovf;
  logic                  busy;
  logic [NUM_TFF-1:0]    tff_we;
  logic [NUM_TFF-1:0]    tff_re;
  logic [NUM_TFF-1:0]    tff_rstb;
  logic [NUM_TFF-1:0]    tff_carry = '0;

  tff_bank_ctrl #(
    .NUM_TFF(NUM_TFF), .NREQ(NREQ), .DUR_W(DUR_W), .CLR_CYC(CLR_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_idx(req_idx), .req_dur(req_dur),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
    .rsp_timeout(rsp_timeout), .rsp_ovf(rsp_ovf), .busy(busy),
    .tff_we(tff_we), .tff_re(tff_re), .tff_rstb(tff_rstb), .tff_carry(tff_carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_val [NUM_TFF] = '{default: 0};
  always @(posedge clk) begin
    for (int i = 0; i < NUM_TFF; i++) begin
      if (!tff_rstb[i]) begin
        m_val[i] <= 0;
        tff_carry[i] <= 1'b0;
      end else if (tff_we[i]) begin
        if (m_val[i] == RING - 1) begin
          m_val[i] <= 0;
          tff_carry[i] <= 1'b1;
        end else begin
          m_val[i] <= m_val[i] + 1;
        end
      end else if (tff_re[i] && m_val[i] != 0) begin
        m_val[i] <= m_val[i] - 1;
        if (m_val[i] == 1) tff_carry[i] <= 1'b1;
      end
    end
  end

  int we_cnt [NUM_TFF] = '{default: 0};
  int re_cnt [NUM_TFF] = '{default: 0};
  int lo_cnt [NUM_TFF] = '{default: 0};
  int we_rise [NUM_TFF] = '{default: -1};
  int re_rise [NUM_TFF] = '{default: -1};
  int rstb_fall [NUM_TFF] = '{default: -1};
  logic [NUM_TFF-1:0] p_we = '0, p_re = '0, p_rstb = '0;
  int rsp_cnt = 0, rsp_cyc = -1, rsp_cnt_v = -1, rsp_id_v = -1, rsp_to_v = -1, rsp_ovf_v = -1;
  int rsp_ids[$];
  int viol_tff = 0, viol_ready = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_TFF; i++) begin
      if (tff_we[i]) we_cnt[i] <= we_cnt[i] + 1;
      if (tff_re[i]) re_cnt[i] <= re_cnt[i] + 1;
      if (!tff_rstb[i]) lo_cnt[i] <= lo_cnt[i] + 1;
      if (tff_we[i] && !p_we[i]) we_rise[i] <= cyc;
      if (tff_re[i] && !p_re[i]) re_rise[i] <= cyc;
      if (!tff_rstb[i] && p_rstb[i]) rstb_fall[i] <= cyc;
    end
    p_we <= tff_we;
    p_re <= tff_re;
    p_rstb <= tff_rstb;
    if ($countones(tff_we | tff_re) > 1 || (tff_we & tff_re) != '0) viol_tff <= viol_tff + 1;
    if ($countones(req_ready) > 1) viol_ready <= viol_ready + 1;
    if (rsp_valid) begin
      rsp_cnt   <= rsp_cnt + 1;
      rsp_cyc   <= cyc;
      rsp_cnt_v <= int'(rsp_count);
      rsp_id_v  <= int'(rsp_id);
      rsp_to_v  <= int'(rsp_timeout);
      rsp_ovf_v <= int'(rsp_ovf);
      rsp_ids.push_back(int'(rsp_id));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int r, input logic op, input int idx, input int dur, output int acc);
    tick();
    req_valid[r] = 1'b1;
    req_op[r] = op;
    req_idx[r*IDX_W +: IDX_W] = IDX_W'(idx);
    req_dur[r*DUR_W +: DUR_W] = DUR_W'(dur);
    acc = -1;
    for (int k = 0; k < 600; k++) begin
      #1;
      if (req_ready[r] === 1'b1) begin
        acc = cyc;
        break;
      end
      tick();
    end
    tick();
    req_valid[r] = 1'b0;
    checks++;
    if (acc < 0) begin errors++; $display("FAIL grant: req %0d saw no req_ready, expected one within 600 cycles", r); end
  endtask

  task automatic wait_rsp(input int base, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (rsp_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rsp_wait: no rsp_valid within %0d cycles, expected one", budget); end
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    tick();
    tick();
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: ready=%b rsp_valid=%b busy=%b, expected 00 0 0", req_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_count !== 8'd0 || rsp_timeout !== 1'b0 || rsp_ovf !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: count=%0d to=%b ovf=%b id=%b, expected all 0", rsp_count, rsp_timeout, rsp_ovf, rsp_id);
    end
    checks++;
    if (tff_we !== 4'h0 || tff_re !== 4'h0 || tff_rstb !== 4'h0) begin
      errors++; $display("FAIL reset_tff: we=%h re=%h rstb=%h, expected 0 0 0", tff_we, tff_re, tff_rstb);
    end
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
    checks++;
    if (tff_rstb !== 4'hF || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: rstb=%h busy=%b, expected f 0", tff_rstb, busy);
    end
  endtask

  task automatic test_write_read();
    int a, base, w0, l0, o0, r0, oe;
    base = rsp_cnt; w0 = we_cnt[1]; l0 = lo_cnt[1]; o0 = lo_cnt[0] + lo_cnt[2] + lo_cnt[3];
    issue(0, OP_WRITE, 1, 5, a);
    wait_rsp(base, 100);
    checks++;
    if (rsp_cyc !== a + 8) begin errors++; $display("FAIL wr_rsp_cycle: got %0d, expected %0d", rsp_cyc, a + 8); end
    checks++;
    if (rsp_cnt_v !== 5 || rsp_to_v !== 0 || rsp_ovf_v !== 0 || rsp_id_v !== 0) begin
      errors++; $display("FAIL wr_rsp: count=%0d to=%0d ovf=%0d id=%0d, expected 5 0 0 0", rsp_cnt_v, rsp_to_v, rsp_ovf_v, rsp_id_v);
    end
    checks++;
    if (rstb_fall[1] !== a + 1 || lo_cnt[1] - l0 !== 2) begin
      errors++; $display("FAIL wr_clear: fall=%0d low=%0d, expected %0d 2", rstb_fall[1], lo_cnt[1] - l0, a + 1);
    end
    checks++;
    if (we_rise[1] !== a + 3 || we_cnt[1] - w0 !== 5) begin
      errors++; $display("FAIL wr_we: rise=%0d high=%0d, expected %0d 5", we_rise[1], we_cnt[1] - w0, a + 3);
    end
    oe = lo_cnt[0] + lo_cnt[2] + lo_cnt[3] - o0;
    checks++;
    if (oe !== 0) begin errors++; $display("FAIL wr_untouched: other rstb low=%0d, expected 0", oe); end

    base = rsp_cnt; r0 = re_cnt[1];
    issue(0, OP_READ, 1, 0, a);
    wait_rsp(base, 300);
    checks++;
    if (rsp_cnt_v < 5 || rsp_cnt_v > 9 || rsp_to_v !== 0) begin
      errors++; $display("FAIL rd_window: count=%0d to=%0d, expected 5..9 and 0", rsp_cnt_v, rsp_to_v);
    end
    checks++;
    if (rsp_cnt_v !== 8 || rsp_ovf_v !== 0 || rsp_cyc !== a + 9) begin
      errors++; $display("FAIL rd_exact: count=%0d ovf=%0d cyc=%0d, expected 8 0 %0d", rsp_cnt_v, rsp_ovf_v, rsp_cyc, a + 9);
    end
    checks++;
    if (re_rise[1] !== a + 1 || re_cnt[1] - r0 !== 8) begin
      errors++; $display("FAIL rd_re: rise=%0d high=%0d, expected %0d 8", re_rise[1], re_cnt[1] - r0, a + 1);
    end
  endtask

  task automatic test_arbitration();
    logic [NREQ-1:0] grants [4];
    logic [NREQ-1:0] exp_g [4];
    int n = 0, base, qb;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    pulse_reset();
    base = rsp_cnt; qb = rsp_ids.size();
    req_op = {OP_WRITE, OP_WRITE};
    req_idx = {2'd2, 2'd0};
    req_dur = {8'd1, 8'd1};
    req_valid = 2'b11;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (req_ready != '0) begin
        grants[n] = req_ready;
        n++;
      end
      if (n == 4) break;
      tick();
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL arb_count: got %0d grants, expected 4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (grants[k] !== exp_g[k]) begin errors++; $display("FAIL arb_order[%0d]: got %b, expected %b", k, grants[k], exp_g[k]); end
    end
    wait_rsp(base + 3, 50);
    for (int k = 0; k < 4 && qb + k < rsp_ids.size(); k++) begin
      checks++;
      if (rsp_ids[qb + k] !== k % 2) begin errors++; $display("FAIL arb_rsp_id[%0d]: got %0d, expected %0d", k, rsp_ids[qb + k], k % 2); end
    end
    checks++;
    if (viol_ready !== 0) begin errors++; $display("FAIL arb_onehot: %0d cycles with >1 ready, expected 0", viol_ready); end
  endtask

  task automatic test_never_written();
    int a, base, r0;
    base = rsp_cnt; r0 = re_cnt[3];
    issue(1, OP_READ, 3, 0, a);
    wait_rsp(base, 400);
    checks++;
    if (rsp_cnt_v !== 255 || rsp_to_v !== 1 || rsp_ovf_v !== 0 || rsp_id_v !== 1) begin
      errors++; $display("FAIL timeout_rsp: count=%0d to=%0d ovf=%0d id=%0d, expected 255 1 0 1", rsp_cnt_v, rsp_to_v, rsp_ovf_v, rsp_id_v);
    end
    checks++;
    if (re_cnt[3] - r0 !== 255 || rsp_cyc !== a + 256) begin
      errors++; $display("FAIL timeout_re: high=%0d cyc=%0d, expected 255 %0d", re_cnt[3] - r0, rsp_cyc, a + 256);
    end
  endtask

  task automatic test_dur_zero();
    int a, base, w0, l0;
    base = rsp_cnt; w0 = we_cnt[3]; l0 = lo_cnt[3];
    issue(0, OP_WRITE, 3, 0, a);
    wait_rsp(base, 50);
    checks++;
    if (rsp_cyc !== a + 3 || rsp_cnt_v !== 0 || rsp_to_v !== 0 || rsp_ovf_v !== 0) begin
      errors++; $display("FAIL dur0_rsp: cyc=%0d count=%0d to=%0d ovf=%0d, expected %0d 0 0 0", rsp_cyc, rsp_cnt_v, rsp_to_v, rsp_ovf_v, a + 3);
    end
    checks++;
    if (we_cnt[3] - w0 !== 0 || lo_cnt[3] - l0 !== 2) begin
      errors++; $display("FAIL dur0_pins: we high=%0d rstb low=%0d, expected 0 2", we_cnt[3] - w0, lo_cnt[3] - l0);
    end
  endtask

  task automatic test_wrap_ovf();
    int a, base, r0;
    base = rsp_cnt;
    issue(0, OP_WRITE, 2, 200, a);
    wait_rsp(base, 300);
    checks++;
    if (rsp_cnt_v !== 200 || rsp_cyc !== a + 203) begin
      errors++; $display("FAIL wrap_write: count=%0d cyc=%0d, expected 200 %0d", rsp_cnt_v, rsp_cyc, a + 203);
    end
    base = rsp_cnt; r0 = re_cnt[2];
    issue(0, OP_READ, 2, 0, a);
    wait_rsp(base, 50);
    checks++;
    if (rsp_ovf_v !== 1 || rsp_cnt_v !== 0 || rsp_to_v !== 0) begin
      errors++; $display("FAIL ovf_rsp: ovf=%0d count=%0d to=%0d, expected 1 0 0", rsp_ovf_v, rsp_cnt_v, rsp_to_v);
    end
    checks++;
    if (re_cnt[2] - r0 !== 1 || rsp_cyc !== a + 2) begin
      errors++; $display("FAIL ovf_re: high=%0d cyc=%0d, expected 1 %0d", re_cnt[2] - r0, rsp_cyc, a + 2);
    end
  endtask

  task automatic test_rst_mid_write();
    int a, base;
    issue(0, OP_WRITE, 0, 20, a);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (tff_we !== 4'b0001) begin errors++; $display("FAIL abort_pre: we=%b, expected 0001", tff_we); end
    base = rsp_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (tff_we !== 4'h0 || tff_rstb !== 4'h0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_now: we=%h rstb=%h busy=%b rsp=%b, expected 0 0 0 0", tff_we, tff_rstb, busy, rsp_valid);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    checks++;
    if (rsp_cnt !== base || tff_we !== 4'h0) begin
      errors++; $display("FAIL abort_quiet: responses=%0d we=%h, expected %0d 0", rsp_cnt, tff_we, base);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_never_written();
    test_dur_zero();
    test_wrap_ovf();
    test_rst_mid_write();
    test_write_read();
    checks++;
    if (viol_tff !== 0) begin errors++; $display("FAIL tff_exclusive: %0d cycles with bad we/re, expected 0", viol_tff); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_bank_ctrl.md
# tff_bank_ctrl

Sequencing controller for a bank of NUM_TFF temporal flip-flops: drives each TFF's WE/RE/rstb pins from one synchronous clock domain. NREQ requesters are round-robin arbitrated into one shared command path. Write commands clear the target TFF, then hold WE for a programmed number of cycles. Read commands hold RE until the TFF's asynchronous carry fires, and return the measured cycle count, which is the stored duration read back.

## Interface
Parameters:
- NUM_TFF, 4, number of TFFs in the bank (power of two, ≥2)
- NREQ, 2, number of requesters (≥1)
- DUR_W, 8, width of durations and counts; MAX_READ = 2**DUR_W-1
- CLR_CYC, 2, cycles tff_rstb is held low before a write (≥1)

Derived: IDX_W = clog2(NUM_TFF).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  one-hot grant/accept strobe
- req_op  in  NREQ  0 = write, 1 = read
- req_idx  in  NREQ*IDX_W  target TFF per requester
- req_dur  in  NREQ*DUR_W  write duration in cycles (ignored for reads)
- rsp_valid  out  1  one-cycle response strobe; no backpressure
- rsp_id  out  clog2(max(NREQ,2))  requester that issued the command
- rsp_count  out  DUR_W  write: dur; read: RE-high cycles
- rsp_timeout  out  1  read hit MAX_READ without carry
- rsp_ovf  out  1  read found carry already set
- busy  out  1  FSM not in IDLE
- tff_we  out  NUM_TFF  TFF write enables
- tff_re  out  NUM_TFF  TFF read enables
- tff_rstb  out  NUM_TFF  TFF active-low resets
- tff_carry  in  NUM_TFF  asynchronous TFF carry outputs

## Operation
Reset values:
- req_ready=0, rsp_* = 0, busy=0
- tff_we=0, tff_re=0
- tff_rstb=all 0 (bank held cleared); drives all 1 from the first clock after rst deasserts
- round-robin pointer=0

FSM states: IDLE, CLR, WRITE, READ, RESP.
- IDLE: if any req_valid, grant the first valid requester at or after the pointer. Assert its req_ready for that cycle and latch op/idx/dur/id. Pointer becomes grantee+1 (mod NREQ). Next state is CLR (write) or READ (read).
- CLR: tff_rstb[idx]=0 for CLR_CYC cycles, then WRITE. If dur=0, go to RESP instead.
- WRITE: tff_we[idx]=1 for exactly dur cycles, then RESP with rsp_count=dur.
- READ: tff_re[idx]=1 and cycle counter increments every cycle. Exits to RESP on the first of:
  - carry_sync rising edge: rsp_count = counter
  - counter = MAX_READ: rsp_timeout=1, rsp_count=MAX_READ
  - synced carry already 1 in the first READ cycle: rsp_ovf=1, rsp_count=0
- RESP: rsp_valid=1 for one cycle with flags, then IDLE. All tff_we/tff_re are 0 in RESP. This gives the guard cycle between operations.

Fixed rules:
- Only the latched index is ever driven; at most one bit of tff_we|tff_re is high.
- WE and RE are never high together.
- Untouched TFFs keep tff_rstb=1.
- Requesters must hold fields stable while valid and not granted.
- Read does not clear the TFF.

## Timing
Accept cycle A is the cycle with req_valid & req_ready.

Write:
- tff_rstb low A+1..A+CLR_CYC
- tff_we high A+CLR_CYC+1..A+CLR_CYC+dur
- rsp_valid at A+CLR_CYC+dur+1

Read:
- tff_re high from A+1
- Sync edge detected in cycle E: tff_re low and rsp_valid at E+1, rsp_count = E-A.
- Carry path adds 2 cycles of synchronizer latency, which is included in the count; calibration is the consumer's concern.

Throughput and reset:
- Next grant no earlier than rsp_valid cycle + 1.
- rst mid-operation aborts immediately to reset values, with no response. All TFFs are cleared via tff_rstb.

## Structure
- Package tff_ctrl_pkg: state enum, OP_WRITE/OP_READ constants.
- Sub-module tff_carry_sync, one per TFF: 2-flop synchronizer plus registered previous value; outputs synced level and rise pulse.
- The rise output of the latched index is muxed into the FSM.

## Test plan
Default parameters; the behavioral TFF model is instantiated ×4.
- Write idx 1, dur 5, then read idx 1:
  - tff_rstb[1] low 2 cycles, tff_we[1] high exactly 5 cycles
  - write rsp_count=5
  - read returns rsp_count within ±2 of 5+2, timeout=0
- Both requesters valid every cycle: grants alternate 0,1,0,1; rsp_id matches; never two req_ready bits high at once.
- Read of a never-written TFF: tff_re high 255 cycles, rsp_timeout=1, rsp_count=255.
- Write with dur 0: no tff_we pulse; rsp_valid at A+3 with count 0.
- Write long enough to wrap the ring (carry set), then read: rsp_ovf=1, rsp_count=0, tff_re high one cycle.
- Assert rst during WRITE: tff_we drops immediately, tff_rstb=0, no rsp_valid. After release, a fresh write/read pair behaves as in the first scenario.
